// File: rtl/model_matrix_transpose_stream.sv
// model_matrix_transpose_stream
//
// This is a streaming matrix transpose engine. It accepts a runtime-sized
// SIZE_I x SIZE_J matrix in row-major order and stores it in a register
// buffer. It then emits the SIZE_J x SIZE_I transpose in row-major order,
// one element per cycle.
//
// Optional feature macro: MATRIX_TRANSPOSE_SIZE_CHECK_EN
//   defined   : an ERROR port is added. A zero size, or a size above its
//               maximum, skips LOAD and DRAIN and produces a READY+ERROR pulse.
//   undefined : no ERROR port. Sizes are clamped when latched
//               (0 -> 1, above the maximum -> MAX_I/MAX_J).
//
// Ports:
//   CLK               clock, all logic on the rising edge
//   RST               synchronous active-high reset
//   START             begin operation, sampled only in IDLE
//   READY             one-cycle pulse when the output stream is complete
//   DATA_IN_I_ENABLE  row-start marker from the source (informational, ignored)
//   DATA_IN_J_ENABLE  element valid; DATA_IN is accepted while in LOAD
//   DATA_OUT_I_ENABLE high with the first element of each output row
//   DATA_OUT_J_ENABLE high with every valid output element
//   SIZE_I_IN         input row count, latched on START
//   SIZE_J_IN         input column count, latched on START
//   DATA_IN           input element
//   ERROR             size error pulse (only when the macro is defined)
//   DATA_OUT          output element, valid while DATA_OUT_J_ENABLE=1
module model_matrix_transpose_stream #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int MAX_I        = 8,
  parameter int MAX_J        = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic                 DATA_IN_I_ENABLE,
  input  logic                 DATA_IN_J_ENABLE,
  output logic                 DATA_OUT_I_ENABLE,
  output logic                 DATA_OUT_J_ENABLE,
  input  logic [DATA_SIZE-1:0] SIZE_I_IN,
  input  logic [DATA_SIZE-1:0] SIZE_J_IN,
  input  logic [DATA_SIZE-1:0] DATA_IN,
`ifdef MATRIX_TRANSPOSE_SIZE_CHECK_EN
  output logic                 ERROR,
`endif
  output logic [DATA_SIZE-1:0] DATA_OUT
);

  localparam int IW = (MAX_I > 1) ? $clog2(MAX_I) : 1;
  localparam int JW = (MAX_J > 1) ? $clog2(MAX_J) : 1;

  localparam logic [DATA_SIZE-1:0] MAX_I_D = DATA_SIZE'(MAX_I);
  localparam logic [DATA_SIZE-1:0] MAX_J_D = DATA_SIZE'(MAX_J);
  localparam logic [IW:0]          MAX_I_S = (IW+1)'(MAX_I);
  localparam logic [JW:0]          MAX_J_S = (JW+1)'(MAX_J);
  localparam logic [IW:0]          ONE_IS  = (IW+1)'(1);
  localparam logic [JW:0]          ONE_JS  = (JW+1)'(1);
  localparam logic [IW-1:0]        ONE_I   = IW'(1);
  localparam logic [JW-1:0]        ONE_J   = JW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_END
  } state_t;

  state_t                 state;
  logic [IW-1:0]          i;
  logic [JW-1:0]          j;
  logic [IW:0]            size_i;
  logic [JW:0]            size_j;
  logic [IW:0]            size_i_clamped;
  logic [JW:0]            size_j_clamped;
  logic                   last_i;
  logic                   last_j;
  logic [DATA_SIZE-1:0]   mem [MAX_I][MAX_J];

  // The row-start marker and the control width have no function here.
  // They exist only so that this model has the same interface as the other
  // models in the library.
  logic unused_inputs;
  assign unused_inputs = DATA_IN_I_ENABLE ^ (CONTROL_SIZE > 0);

  // The clamped size always fits in the counter width + 1. When a size is in
  // range, the clamped value is just that size, truncated to this width.
  always_comb begin
    if (SIZE_I_IN == '0)          size_i_clamped = ONE_IS;
    else if (SIZE_I_IN > MAX_I_D) size_i_clamped = MAX_I_S;
    else                          size_i_clamped = SIZE_I_IN[IW:0];
    if (SIZE_J_IN == '0)          size_j_clamped = ONE_JS;
    else if (SIZE_J_IN > MAX_J_D) size_j_clamped = MAX_J_S;
    else                          size_j_clamped = SIZE_J_IN[JW:0];
  end

`ifdef MATRIX_TRANSPOSE_SIZE_CHECK_EN
  logic size_bad;
  logic size_err;
  assign size_bad = (SIZE_I_IN == '0) || (SIZE_I_IN > MAX_I_D) ||
                    (SIZE_J_IN == '0) || (SIZE_J_IN > MAX_J_D);
`endif

  assign last_i = ({1'b0, i} == size_i - ONE_IS);
  assign last_j = ({1'b0, j} == size_j - ONE_JS);

  // The buffer is not reset. Writes happen only on accepted LOAD beats.
  always_ff @(posedge CLK) begin
    if (!RST && state == S_LOAD && DATA_IN_J_ENABLE)
      mem[i][j] <= DATA_IN;
  end

  // END lasts two cycles. In the first, READY is raised. In the second,
  // READY is dropped. This keeps the FSM in END while READY is visible, so a
  // START that coincides with the pulse is ignored.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state             <= S_IDLE;
      i                 <= '0;
      j                 <= '0;
      READY             <= 1'b0;
      DATA_OUT_I_ENABLE <= 1'b0;
      DATA_OUT_J_ENABLE <= 1'b0;
      DATA_OUT          <= '0;
`ifdef MATRIX_TRANSPOSE_SIZE_CHECK_EN
      ERROR             <= 1'b0;
      size_err          <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          READY             <= 1'b0;
          DATA_OUT_I_ENABLE <= 1'b0;
          DATA_OUT_J_ENABLE <= 1'b0;
`ifdef MATRIX_TRANSPOSE_SIZE_CHECK_EN
          ERROR             <= 1'b0;
`endif
          if (START) begin
            size_i <= size_i_clamped;
            size_j <= size_j_clamped;
            i      <= '0;
            j      <= '0;
`ifdef MATRIX_TRANSPOSE_SIZE_CHECK_EN
            size_err <= size_bad;
            state    <= size_bad ? S_END : S_LOAD;
`else
            state    <= S_LOAD;
`endif
          end
        end
        S_LOAD: begin
          if (DATA_IN_J_ENABLE) begin
            if (last_j) begin
              j <= '0;
              if (last_i) begin
                i     <= '0;
                state <= S_DRAIN;
              end else begin
                i <= i + ONE_I;
              end
            end else begin
              j <= j + ONE_J;
            end
          end
        end
        S_DRAIN: begin
          // The row index is the inner loop, so each output row walks down
          // one input column.
          DATA_OUT          <= mem[i][j];
          DATA_OUT_J_ENABLE <= 1'b1;
          DATA_OUT_I_ENABLE <= (i == '0);
          if (last_i) begin
            i <= '0;
            if (last_j) begin
              j     <= '0;
              state <= S_END;
            end else begin
              j <= j + ONE_J;
            end
          end else begin
            i <= i + ONE_I;
          end
        end
        S_END: begin
          DATA_OUT_I_ENABLE <= 1'b0;
          DATA_OUT_J_ENABLE <= 1'b0;
          if (!READY) begin
            READY <= 1'b1;
`ifdef MATRIX_TRANSPOSE_SIZE_CHECK_EN
            ERROR <= size_err;
`endif
          end else begin
            READY <= 1'b0;
`ifdef MATRIX_TRANSPOSE_SIZE_CHECK_EN
            ERROR <= 1'b0;
`endif
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
